// File: rtl/paddle_motion.sv
// Paddle motion engine: turns up/down command levels into the paddle centre Y.
// Position moves one pixel per period clocks with hold-to-boost, clamp or wrap.
// Ports: clk, reset (async active-high), up/down/game_on/wrap_mode/ticks_per_px
//        inputs; position, moving_up, moving_down, at_limit outputs.
module paddle_motion #(
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 80,
  parameter int START_POS   = 240,
  parameter int BOOST_STEPS = 16,
  parameter int POS_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             game_on,
  input  logic             wrap_mode,
  input  logic [31:0]      ticks_per_px,
  output logic [POS_W-1:0] position,
  output logic             moving_up,
  output logic             moving_down,
  output logic             at_limit
);

  localparam logic [POS_W-1:0] MIN_POS   = POS_W'(PADDLE_H / 2);
  localparam logic [POS_W-1:0] MAX_POS   = POS_W'(SCREEN_H - PADDLE_H / 2);
  localparam logic [POS_W-1:0] START_P   = POS_W'(START_POS);
  localparam int               RUN_W     = $clog2(BOOST_STEPS + 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(BOOST_STEPS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      cnt;
  logic [RUN_W-1:0] step_run;
  logic             boost;

  logic             cmd_up;
  logic             cmd_dn;
  logic [31:0]      period;
  logic             step_due;
  logic [POS_W-1:0] up_target;
  logic [POS_W-1:0] dn_target;
  logic             up_held;
  logic             dn_held;
  logic [RUN_W-1:0] run_inc;

  // Both buttons pressed cancel out; game_on gates everything.
  assign cmd_up = up & ~down & game_on;
  assign cmd_dn = down & ~up & game_on;

  always_comb begin
    period = 32'd1;
    if (boost) begin
      if (ticks_per_px[31:1] != 31'd0) period = {1'b0, ticks_per_px[31:1]};
    end else begin
      if (ticks_per_px != 32'd0) period = ticks_per_px;
    end
  end

  // ">=" rather than "==" so a period that shrinks mid-run steps immediately
  // instead of waiting for cnt to wrap.
  assign step_due = (cnt >= period - 32'd1);

  always_comb begin
    up_held   = 1'b0;
    up_target = position - POS_W'(1);
    if (position == MIN_POS) begin
      up_held   = ~wrap_mode;
      up_target = wrap_mode ? MAX_POS : position;
    end
    dn_held   = 1'b0;
    dn_target = position + POS_W'(1);
    if (position == MAX_POS) begin
      dn_held   = ~wrap_mode;
      dn_target = wrap_mode ? MIN_POS : position;
    end
  end

  assign run_inc  = (step_run == RUN_MAX) ? step_run : step_run + RUN_W'(1);
  assign at_limit = (position == MIN_POS) || (position == MAX_POS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      position    <= START_P;
      cnt         <= 32'd0;
      step_run    <= '0;
      boost       <= 1'b0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 32'd0;
          if (cmd_up) begin
            state     <= MOVE_UP;
            moving_up <= 1'b1;
          end else if (cmd_dn) begin
            state       <= MOVE_DOWN;
            moving_down <= 1'b1;
          end
        end

        MOVE_UP: begin
          if (cmd_up) begin
            if (step_due) begin
              cnt      <= 32'd0;
              position <= up_target;
              // A clamped step is not progress, so it does not feed boost.
              if (!up_held) begin
                step_run <= run_inc;
                if (run_inc == RUN_MAX) boost <= 1'b1;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else begin
            cnt       <= 32'd0;
            step_run  <= '0;
            boost     <= 1'b0;
            moving_up <= 1'b0;
            if (cmd_dn) begin
              state       <= MOVE_DOWN;
              moving_down <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        MOVE_DOWN: begin
          if (cmd_dn) begin
            if (step_due) begin
              cnt      <= 32'd0;
              position <= dn_target;
              if (!dn_held) begin
                step_run <= run_inc;
                if (run_inc == RUN_MAX) boost <= 1'b1;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else begin
            cnt         <= 32'd0;
            step_run    <= '0;
            boost       <= 1'b0;
            moving_down <= 1'b0;
            if (cmd_up) begin
              state     <= MOVE_UP;
              moving_up <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state       <= IDLE;
          cnt         <= 32'd0;
          step_run    <= '0;
          boost       <= 1'b0;
          moving_up   <= 1'b0;
          moving_down <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_motion.sv
module tb_paddle_motion;

  logic        clk = 1'b0;
  logic        reset;
  logic        up;
  logic        down;
  logic        game_on;
  logic        wrap_mode;
  logic [31:0] ticks_per_px;
  logic [31:0] position;
  logic        moving_up;
  logic        moving_down;
  logic        at_limit;

  int passed = 0;
  int total  = 0;

  paddle_motion dut (
    .clk         (clk),
    .reset       (reset),
    .up          (up),
    .down        (down),
    .game_on     (game_on),
    .wrap_mode   (wrap_mode),
    .ticks_per_px(ticks_per_px),
    .position    (position),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .at_limit    (at_limit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset deasserted just after an edge; the next edge is the IDLE edge.
  task automatic do_reset(input logic [31:0] tpp, input logic u, input logic d,
                          input logic wm);
    reset        = 1'b1;
    up           = u;
    down         = d;
    game_on      = 1'b1;
    wrap_mode    = wm;
    ticks_per_px = tpp;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'd4, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    total++;
    if (position !== 32'd240 || moving_up !== 1'b0 || moving_down !== 1'b0 || at_limit !== 1'b0)
      $display("FAIL reset_state: pos=%0d mu=%b md=%b lim=%b, required pos=240 mu=0 md=0 lim=0",
               position, moving_up, moving_down, at_limit);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_up_step();
    do_reset(32'd4, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if (moving_up !== 1'b1 || position !== 32'd240)
      $display("FAIL up_entry: mu=%b pos=%0d, required mu=1 pos=240", moving_up, position);
    else passed++;
    repeat (3) tick();
    total++;
    if (position !== 32'd240)
      $display("FAIL up_before_first_step: pos=%0d, required 240", position);
    else passed++;
    tick();
    total++;
    if (position !== 32'd239)
      $display("FAIL up_first_step: pos=%0d, required 239", position);
    else passed++;
    for (int k = 1; k <= 2; k++) begin
      repeat (4) tick();
      total++;
      if (position !== 32'(239 - k))
        $display("FAIL up_step_%0d: pos=%0d, required %0d", k + 1, position, 239 - k);
      else passed++;
    end
    up = 1'b0;
    tick();
    total++;
    if (moving_up !== 1'b0 || position !== 32'd237)
      $display("FAIL up_release: mu=%b pos=%0d, required mu=0 pos=237", moving_up, position);
    else passed++;
  endtask

  task automatic test_boost();
    int bad;
    do_reset(32'd2, 1'b0, 1'b1, 1'b0);
    tick();
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (position !== 32'(240 + k - 1)) bad++;
      tick();
      if (position !== 32'(240 + k)) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL boost_pre_steps: %0d wrong samples, pos=%0d, required 256", bad, position);
    else passed++;
    bad = 0;
    for (int k = 17; k <= 20; k++) begin
      tick();
      if (position !== 32'(240 + k)) bad++;
    end
    total++;
    if (bad != 0 || position !== 32'd260)
      $display("FAIL boost_fast_steps: %0d wrong, pos=%0d, required 260", bad, position);
    else passed++;
    down = 1'b0;
    tick();
    total++;
    if (moving_down !== 1'b0 || position !== 32'd260)
      $display("FAIL boost_release: md=%b pos=%0d, required md=0 pos=260", moving_down, position);
    else passed++;
    // Boost must have been cleared: the first step is back to 2 clocks.
    down = 1'b1;
    tick();
    tick();
    total++;
    if (position !== 32'd260)
      $display("FAIL boost_cleared: pos=%0d, required 260", position);
    else passed++;
    tick();
    total++;
    if (position !== 32'd261)
      $display("FAIL boost_cleared_step: pos=%0d, required 261", position);
    else passed++;
    down = 1'b0;
  endtask

  task automatic test_clamp();
    do_reset(32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    repeat (200) tick();
    total++;
    if (position !== 32'd40 || at_limit !== 1'b1)
      $display("FAIL clamp_reach_min: pos=%0d lim=%b, required pos=40 lim=1", position, at_limit);
    else passed++;
    repeat (3) tick();
    total++;
    if (position !== 32'd40 || at_limit !== 1'b1 || moving_up !== 1'b1)
      $display("FAIL clamp_hold: pos=%0d lim=%b mu=%b, required pos=40 lim=1 mu=1",
               position, at_limit, moving_up);
    else passed++;
    wrap_mode = 1'b1;
    tick();
    total++;
    if (position !== 32'd440 || at_limit !== 1'b1)
      $display("FAIL clamp_then_wrap: pos=%0d lim=%b, required pos=440 lim=1", position, at_limit);
    else passed++;
    up = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset(32'd4, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    total++;
    if (moving_up !== 1'b0 || moving_down !== 1'b0 || position !== 32'd240)
      $display("FAIL both_pressed: mu=%b md=%b pos=%0d, required 0 0 240",
               moving_up, moving_down, position);
    else passed++;
    down = 1'b0;
    tick();
    tick();
    up   = 1'b0;
    down = 1'b1;
    tick();
    total++;
    if (moving_up !== 1'b0 || moving_down !== 1'b1 || position !== 32'd240)
      $display("FAIL reversal: mu=%b md=%b pos=%0d, required mu=0 md=1 pos=240",
               moving_up, moving_down, position);
    else passed++;
    repeat (3) tick();
    total++;
    if (position !== 32'd240)
      $display("FAIL reversal_no_early_step: pos=%0d, required 240", position);
    else passed++;
    tick();
    total++;
    if (position !== 32'd241)
      $display("FAIL reversal_first_step: pos=%0d, required 241", position);
    else passed++;
    down = 1'b0;
  endtask

  task automatic test_wrap_down();
    do_reset(32'd0, 1'b0, 1'b1, 1'b1);
    tick();
    repeat (200) tick();
    total++;
    if (position !== 32'd440 || at_limit !== 1'b1)
      $display("FAIL wrap_reach_max: pos=%0d lim=%b, required pos=440 lim=1", position, at_limit);
    else passed++;
    tick();
    total++;
    if (position !== 32'd40)
      $display("FAIL wrap_to_min: pos=%0d, required 40", position);
    else passed++;
    tick();
    total++;
    if (position !== 32'd41 || at_limit !== 1'b0)
      $display("FAIL wrap_continue: pos=%0d lim=%b, required pos=41 lim=0", position, at_limit);
    else passed++;
    down = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset(32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    repeat (60) tick();
    total++;
    if (position !== 32'd300)
      $display("FAIL async_setup: pos=%0d, required 300", position);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (position !== 32'd240 || moving_down !== 1'b0 || moving_up !== 1'b0)
      $display("FAIL async_reset: pos=%0d mu=%b md=%b, required pos=240 mu=0 md=0",
               position, moving_up, moving_down);
    else passed++;
    tick();
    reset = 1'b0;
    down  = 1'b0;
  endtask

  task automatic test_game_off();
    do_reset(32'd1, 1'b0, 1'b1, 1'b0);
    tick();
    repeat (5) tick();
    total++;
    if (position !== 32'd245)
      $display("FAIL game_setup: pos=%0d, required 245", position);
    else passed++;
    game_on = 1'b0;
    tick();
    tick();
    total++;
    if (moving_down !== 1'b0 || position !== 32'd245)
      $display("FAIL game_off_freeze: md=%b pos=%0d, required md=0 pos=245", moving_down, position);
    else passed++;
    game_on = 1'b1;
    tick();
    total++;
    if (moving_down !== 1'b1 || position !== 32'd245)
      $display("FAIL game_resume_entry: md=%b pos=%0d, required md=1 pos=245", moving_down, position);
    else passed++;
    tick();
    total++;
    if (position !== 32'd246)
      $display("FAIL game_resume_step: pos=%0d, required 246", position);
    else passed++;
    down = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    up           = 1'b0;
    down         = 1'b0;
    game_on      = 1'b0;
    wrap_mode    = 1'b0;
    ticks_per_px = 32'd4;
    test_reset();
    test_up_step();
    test_boost();
    test_clamp();
    test_simultaneous();
    test_wrap_down();
    test_async_reset();
    test_game_off();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
